// File: rtl/disp_arbiter.sv
// Round-robin arbiter that lets three requesters share one 4-digit BCD display,
// holding each accepted value for DWELL cycles. Optional feature macro: DISP_BCD_CHECK_EN.
module disp_arbiter #(
  parameter logic [25:0] DWELL = 26'd25000000
) (
  input  logic        CLK_50M,
  input  logic        RST,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  ack,
  output logic [15:0] disp_data,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        err
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      r_state;
  logic [25:0] r_cnt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_owner;
  logic [15:0] r_dispData;
  logic [2:0]  r_ack;

  logic        w_found;
  logic [1:0]  w_sel;
  logic [1:0]  w_idx;
  logic [15:0] w_selData;
  logic        w_accept;

  function automatic logic [1:0] mod3(input logic [2:0] s);
    logic [2:0] t;
    t = (s >= 3'd3) ? s - 3'd3 : s;
    return t[1:0];
  endfunction

  // Search starts just after the last grant so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_idx   = r_ptr;
    for (int k = 1; k <= 3; k++) begin
      w_idx = mod3({1'b0, r_ptr} + 3'(k));
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    case (w_sel)
      2'd0:    w_selData = data0;
      2'd1:    w_selData = data1;
      default: w_selData = data2;
    endcase
  end

`ifdef DISP_BCD_CHECK_EN
  logic r_err;
  assign w_accept = (w_selData[3:0]   <= 4'd9) && (w_selData[7:4]   <= 4'd9) &&
                    (w_selData[11:8]  <= 4'd9) && (w_selData[15:12] <= 4'd9);
  assign err      = r_err;
`else
  assign w_accept = 1'b1;
  assign err      = 1'b0;
`endif

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= 26'd0;
      r_ptr      <= 2'd2;
      r_owner    <= 2'd3;
      r_dispData <= 16'h0000;
      r_ack      <= 3'b000;
`ifdef DISP_BCD_CHECK_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_ack <= 3'b000;
`ifdef DISP_BCD_CHECK_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_found) begin
            // A rejected value still consumes its round-robin turn.
            r_ack <= 3'b001 << w_sel;
            r_ptr <= w_sel;
`ifdef DISP_BCD_CHECK_EN
            r_err <= ~w_accept;
`endif
            if (w_accept) begin
              r_dispData <= w_selData;
              r_owner    <= w_sel;
              r_cnt      <= 26'd0;
              r_state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (r_cnt == DWELL - 26'd1) begin
            r_cnt   <= 26'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 26'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign disp_data = r_dispData;
  assign owner     = r_owner;
  assign busy      = (r_state == HOLD);

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter with DWELL=4: directed vector table,
// hand-written corner sequences, then random traffic against a countdown model.
module tb_disp_arbiter;

  localparam logic [25:0] DW = 26'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] d0, d1, d2;
  logic [2:0]  ack;
  logic [15:0] dispData;
  logic [1:0]  owner;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  disp_arbiter #(.DWELL(DW)) dut (
    .CLK_50M   (clk),
    .RST       (rst),
    .req       (req),
    .data0     (d0),
    .data1     (d1),
    .data2     (d2),
    .ack       (ack),
    .disp_data (dispData),
    .owner     (owner),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  ack;
    logic [15:0] data;
    logic [1:0]  owner;
    logic        busy;
  } vec_t;

  vec_t vecs[13];

  // Reference model: remaining hold cycles plus last-grant bookkeeping.
  int          mHold;
  int          mPtr;
  logic [15:0] mData;
  logic [1:0]  mOwner;
  logic [2:0]  mAck;
  logic        mErr;

  function automatic bit badBcd(input logic [15:0] v);
    for (int n = 0; n < 4; n++)
      if (((v >> (4 * n)) & 16'hF) > 16'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelEdge();
    int idx;
    logic [15:0] v;
    mAck = 3'b000;
    mErr = 1'b0;
    if (rst) begin
      mHold = 0; mPtr = 2; mData = 16'h0000; mOwner = 2'd3;
    end else if (mHold > 0) begin
      mHold = mHold - 1;
    end else if (req != 3'b000) begin
      idx = -1;
      for (int k = 1; k <= 3; k++)
        if (idx < 0 && req[(mPtr + k) % 3]) idx = (mPtr + k) % 3;
      v = (idx == 0) ? d0 : (idx == 1) ? d1 : d2;
      mAck = 3'(1 << idx);
      mPtr = idx;
`ifdef DISP_BCD_CHECK_EN
      if (badBcd(v)) begin
        mErr = 1'b1;
      end else begin
        mData = v; mOwner = 2'(idx); mHold = int'(DW);
      end
`else
      mData = v; mOwner = 2'(idx); mHold = int'(DW);
`endif
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] q,
                               input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    rst = r; req = q; d0 = a; d1 = b; d2 = c;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] eAck, input logic [15:0] eData,
                             input logic [1:0] eOwner, input logic eBusy, input logic eErr);
    checkField({tag, ".ack"},   32'(ack),      32'(eAck));
    checkField({tag, ".data"},  32'(dispData), 32'(eData));
    checkField({tag, ".owner"}, 32'(owner),    32'(eOwner));
    checkField({tag, ".busy"},  32'(busy),     32'(eBusy));
    checkField({tag, ".err"},   32'(err),      32'(eErr));
  endtask

  initial begin
    applyStimulus(1'b1, 3'b111, 16'h1234, 16'h5678, 16'h0042);

    // Reset with all requests up, grant 0, a late req1 waiting out the hold, mid-hold reset.
    vecs[0]  = '{1'b1, 3'b111, 3'b000, 16'h0000, 2'd3, 1'b0};
    vecs[1]  = '{1'b1, 3'b111, 3'b000, 16'h0000, 2'd3, 1'b0};
    vecs[2]  = '{1'b0, 3'b001, 3'b001, 16'h1234, 2'd0, 1'b1};
    vecs[3]  = '{1'b0, 3'b000, 3'b000, 16'h1234, 2'd0, 1'b1};
    vecs[4]  = '{1'b0, 3'b010, 3'b000, 16'h1234, 2'd0, 1'b1};
    vecs[5]  = '{1'b0, 3'b010, 3'b000, 16'h1234, 2'd0, 1'b1};
    vecs[6]  = '{1'b0, 3'b010, 3'b000, 16'h1234, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 3'b010, 3'b010, 16'h5678, 2'd1, 1'b1};
    vecs[8]  = '{1'b0, 3'b000, 3'b000, 16'h5678, 2'd1, 1'b1};
    vecs[9]  = '{1'b0, 3'b000, 3'b000, 16'h5678, 2'd1, 1'b1};
    vecs[10] = '{1'b1, 3'b100, 3'b000, 16'h0000, 2'd3, 1'b0};
    vecs[11] = '{1'b0, 3'b100, 3'b100, 16'h0042, 2'd2, 1'b1};
    vecs[12] = '{1'b0, 3'b000, 3'b000, 16'h0042, 2'd2, 1'b1};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, 16'h1234, 16'h5678, 16'h0042);
      clockEdge();
      checkOutput($sformatf("vec%0d", i), vecs[i].ack, vecs[i].data,
                  vecs[i].owner, vecs[i].busy, 1'b0);
    end

    // Constant requests from everyone: grants rotate 0,1,2,0 every DWELL+1 cycles.
    applyStimulus(1'b1, 3'b000, 16'h0001, 16'h0002, 16'h0003);
    clockEdge();
    for (int c = 0; c < 20; c++) begin
      int g;
      g = (c / 5) % 3;
      applyStimulus(1'b0, 3'b111, 16'h0001, 16'h0002, 16'h0003);
      clockEdge();
      checkOutput($sformatf("rr%0d", c), (c % 5 == 0) ? 3'(1 << g) : 3'b000,
                  16'(g + 1), 2'(g), (c % 5 != 4), 1'b0);
    end

    // Non-BCD value offered after a good grant has finished its hold.
    applyStimulus(1'b1, 3'b000, 16'h0000, 16'h0000, 16'h0000);
    clockEdge();
    applyStimulus(1'b0, 3'b001, 16'h1234, 16'h0000, 16'h0000);
    clockEdge();
    checkOutput("bcdGood", 3'b001, 16'h1234, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b000, 16'h1234, 16'h0000, 16'h0000);
    repeat (4) clockEdge();
    checkOutput("bcdIdle", 3'b000, 16'h1234, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b001, 16'h12A4, 16'h0000, 16'h0000);
    clockEdge();
`ifdef DISP_BCD_CHECK_EN
    checkOutput("bcdBad", 3'b001, 16'h1234, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'b000, 16'h12A4, 16'h0000, 16'h0000);
    clockEdge();
    checkOutput("bcdAfter", 3'b000, 16'h1234, 2'd0, 1'b0, 1'b0);
`else
    checkOutput("bcdBad", 3'b001, 16'h12A4, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b000, 16'h12A4, 16'h0000, 16'h0000);
    clockEdge();
    checkOutput("bcdAfter", 3'b000, 16'h12A4, 2'd0, 1'b1, 1'b0);
`endif

    // Random traffic with occasional resets, compared every cycle to the model.
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] a, b, e;
      a = (c % 3 == 0) ? 16'($urandom) : 16'h0000 | 16'($urandom_range(0, 9999));
      b = 16'($urandom);
      e = 16'({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
      applyStimulus((c == 0) || ($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7)), a, b, e);
      modelEdge();
      clockEdge();
      checkOutput($sformatf("rnd%0d", c), mAck, mData, mOwner, (mHold > 0), mErr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
